// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS data-side pipeline blocks.
//   SB_DEPTH_DEFAULT : default number of entries in the store buffer
//   sb_entry_t       : one buffered store, word address plus data word
//   wordAddr()       : byte address -> word address (drops bits [1:0])
//   byteAddr()       : word address -> word-aligned byte address
// ---------------------------------------------------------------------------
package mips_pkg;

    localparam int SB_DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] data;
    } sb_entry_t;

    // Loads and stores are word sized, so the two byte-offset bits are
    // simply discarded everywhere an address is compared or stored.
    function automatic logic [29:0] wordAddr(input logic [31:0] addr);
        return addr[31:2];
    endfunction

    function automatic logic [31:0] byteAddr(input logic [29:0] waddr);
        return {waddr, 2'b00};
    endfunction

endpackage

// File: rtl/store_buffer_if.sv
// ---------------------------------------------------------------------------
// store_buffer_if
// Bundles the MEM-stage store/load handshake, the data-memory port and the
// occupancy status of the store buffer.
//   st_valid/st_addr/st_data/st_ready : word store handshake
//   ld_valid/ld_addr                  : word load request
//   ld_data/ld_fwd/ld_stall           : load result, forward flag, stall
//   mem_addr/mem_we/mem_wd/mem_rd     : data memory (comb read, posedge write)
//   sb_empty/sb_count                 : occupancy
// Modport slave is used by the store buffer, master by the MEM stage.
// ---------------------------------------------------------------------------
interface store_buffer_if
    import mips_pkg::*;
#(
    parameter int SB_DEPTH = SB_DEPTH_DEFAULT
);

    logic                        st_valid;
    logic [31:0]                 st_addr;
    logic [31:0]                 st_data;
    logic                        st_ready;
    logic                        ld_valid;
    logic [31:0]                 ld_addr;
    logic [31:0]                 ld_data;
    logic                        ld_fwd;
    logic                        ld_stall;
    logic [31:0]                 mem_addr;
    logic                        mem_we;
    logic [31:0]                 mem_wd;
    logic [31:0]                 mem_rd;
    logic                        sb_empty;
    logic [$clog2(SB_DEPTH):0]   sb_count;

    modport slave (
        input  st_valid, st_addr, st_data, ld_valid, ld_addr, mem_rd,
        output st_ready, ld_data, ld_fwd, ld_stall,
               mem_addr, mem_we, mem_wd, sb_empty, sb_count
    );

    modport master (
        output st_valid, st_addr, st_data, ld_valid, ld_addr, mem_rd,
        input  st_ready, ld_data, ld_fwd, ld_stall,
               mem_addr, mem_we, mem_wd, sb_empty, sb_count
    );

endinterface

// File: rtl/store_buffer_fwd.sv
// ---------------------------------------------------------------------------
// store_buffer_fwd
// Combinational youngest-match search over the store buffer entries.
//   i_entries   : buffer storage, indexed by physical slot
//   i_validMask : one bit per physical slot, set when the slot holds a store
//   i_headPtr   : slot of the oldest entry
//   i_ldWaddr   : word address of the load being serviced
//   o_hit       : some valid entry matches the load address
//   o_data      : data of the youngest matching entry (0 when no hit)
// ---------------------------------------------------------------------------
module store_buffer_fwd
    import mips_pkg::*;
#(
    parameter int SB_DEPTH = SB_DEPTH_DEFAULT,
    localparam int PTR_W = $clog2(SB_DEPTH)
) (
    input  sb_entry_t           i_entries [SB_DEPTH],
    input  logic [SB_DEPTH-1:0] i_validMask,
    input  logic [PTR_W-1:0]    i_headPtr,
    input  logic [29:0]         i_ldWaddr,
    output logic                o_hit,
    output logic [31:0]         o_data
);

    logic [PTR_W-1:0] w_idx;

    // Walk the slots from oldest to youngest starting at the head pointer.
    // A later match overwrites an earlier one, so whatever is left at the
    // end of the loop is the youngest store to that word.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        w_idx  = '0;
        for (int k = 0; k < SB_DEPTH; k++) begin
            w_idx = i_headPtr + PTR_W'(k);
            if (i_validMask[w_idx] && (i_entries[w_idx].waddr == i_ldWaddr)) begin
                o_hit  = 1'b1;
                o_data = i_entries[w_idx].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// ---------------------------------------------------------------------------
// store_buffer
// Word store buffer between the MEM stage and the data memory. Stores are
// queued in program order and written back one per cycle whenever the memory
// port is not needed by a load; loads see the youngest buffered store to the
// same word before falling back to memory.
//   clk : single clock, all state on posedge
//   rst : synchronous active-high reset, discards buffered stores
//   sb  : store_buffer_if.slave (store/load handshake, memory port, status)
// ---------------------------------------------------------------------------
module store_buffer
    import mips_pkg::*;
#(
    parameter int SB_DEPTH = SB_DEPTH_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    store_buffer_if.slave  sb
);

    localparam int PTR_W   = $clog2(SB_DEPTH);
    localparam int COUNT_W = PTR_W + 1;

    sb_entry_t           r_entries [SB_DEPTH];
    logic [PTR_W-1:0]    r_headPtr;
    logic [PTR_W-1:0]    r_tailPtr;
    logic [COUNT_W-1:0]  r_count;

    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_drain;
    logic                w_loadSvc;
    logic                w_fwdHit;
    logic [31:0]         w_fwdData;
    logic [SB_DEPTH-1:0] w_validMask;
    logic [PTR_W-1:0]    w_offset;
    sb_entry_t           w_head;

    // Occupancy is tracked with an explicit count so full and empty never
    // alias even though the pointers wrap onto each other.
    assign w_full  = (r_count == COUNT_W'(SB_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_head  = r_entries[r_headPtr];

    // A store is only taken when there is room before this edge; a drain in
    // the same cycle does not make room for it. Reset cycles never push.
    assign w_push    = sb.st_valid && !w_full && !rst;
    assign w_loadSvc = sb.ld_valid && !w_full;

    // The memory port goes to a load whenever one can be serviced; the head
    // entry only drains when the port is idle or the buffer is full. A reset
    // cycle never drains, so discarded stores never reach memory.
    assign w_drain = !w_empty && (!sb.ld_valid || w_full) && !rst;

    // Mark which physical slots currently hold a store: a slot is live when
    // its distance from the head is below the occupancy count.
    always_comb begin
        w_validMask = '0;
        w_offset    = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            w_offset       = PTR_W'(i) - r_headPtr;
            w_validMask[i] = ({1'b0, w_offset} < r_count);
        end
    end

    store_buffer_fwd #(
        .SB_DEPTH (SB_DEPTH)
    ) u_fwd (
        .i_entries   (r_entries),
        .i_validMask (w_validMask),
        .i_headPtr   (r_headPtr),
        .i_ldWaddr   (wordAddr(sb.ld_addr)),
        .o_hit       (w_fwdHit),
        .o_data      (w_fwdData)
    );

    // Memory port arbitration: load address first, else the drain of the
    // head entry, else everything held at zero.
    always_comb begin
        sb.mem_addr = '0;
        sb.mem_we   = 1'b0;
        sb.mem_wd   = '0;
        if (w_loadSvc) begin
            sb.mem_addr = byteAddr(wordAddr(sb.ld_addr));
        end else if (w_drain) begin
            sb.mem_addr = byteAddr(w_head.waddr);
            sb.mem_we   = 1'b1;
            sb.mem_wd   = w_head.data;
        end
    end

    // Load result and status. A store pushed this cycle is not yet in the
    // entry array, so it is naturally invisible to a load in the same cycle.
    always_comb begin
        sb.st_ready = !w_full;
        sb.ld_stall = sb.ld_valid && w_full;
        sb.ld_fwd   = w_loadSvc && w_fwdHit;
        sb.ld_data  = w_fwdHit ? w_fwdData : sb.mem_rd;
        sb.sb_empty = w_empty;
        sb.sb_count = r_count;
    end

    // Entry storage carries no reset; the count alone decides which slots
    // hold live data.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_entries[r_tailPtr] <= '{waddr: wordAddr(sb.st_addr), data: sb.st_data};
        end
    end

    // Pointer and occupancy update. Pointers wrap naturally because the
    // depth is a power of two; a simultaneous push and pop leaves the count
    // unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_headPtr <= '0;
            r_tailPtr <= '0;
            r_count   <= '0;
        end else begin
            if (w_push) begin
                r_tailPtr <= r_tailPtr + PTR_W'(1);
            end
            if (w_drain) begin
                r_headPtr <= r_headPtr + PTR_W'(1);
            end
            if (w_push && !w_drain) begin
                r_count <= r_count + COUNT_W'(1);
            end else if (!w_push && w_drain) begin
                r_count <= r_count - COUNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// ---------------------------------------------------------------------------
// tb_store_buffer
// Directed bench for store_buffer. Stimulus pushes the expected memory
// writes and load results into queues; a monitor on the falling edge pops
// and compares whenever the DUT writes memory or services a load. A small
// word memory model answers mem_rd and records writes.
// ---------------------------------------------------------------------------
module tb_store_buffer;
    import mips_pkg::*;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wrExp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        fwd;
    } ldExp_t;

    logic clk = 1'b0;
    logic rst;

    int testsRun    = 0;
    int testsFailed = 0;

    wrExp_t wrQ[$];
    ldExp_t ldQ[$];

    logic [31:0] mem    [0:255];
    logic [31:0] expMem [0:255];

    store_buffer_if #(.SB_DEPTH(DEPTH)) sb();

    store_buffer #(
        .SB_DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Data memory model: combinational read, posedge write.
    assign sb.mem_rd = mem[sb.mem_addr[9:2]];

    always @(posedge clk) begin
        if (sb.mem_we) begin
            mem[sb.mem_addr[9:2]] <= sb.mem_wd;
        end
    end

    function automatic logic [31:0] initWord(input int idx);
        return 32'hD000_0000 | 32'(idx);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic expectWrite(input logic [31:0] addr, input logic [31:0] data);
        wrExp_t w;
        w.addr = {addr[31:2], 2'b00};
        w.data = data;
        wrQ.push_back(w);
        expMem[addr[9:2]] = data;
    endtask

    task automatic expectLoad(input logic [31:0] addr, input logic [31:0] data,
                              input logic fwd);
        ldExp_t l;
        l.addr = {addr[31:2], 2'b00};
        l.data = data;
        l.fwd  = fwd;
        ldQ.push_back(l);
    endtask

    // One cycle: drive inputs just after the rising edge, return just after
    // the falling edge so direct checks see settled outputs and the monitor
    // has already consumed this cycle's events.
    task automatic applyStimulus(input logic stv, input logic [31:0] sa,
                                 input logic [31:0] sd, input logic ldv,
                                 input logic [31:0] la);
        @(posedge clk);
        #1;
        rst         = 1'b0;
        sb.st_valid = stv;
        sb.st_addr  = sa;
        sb.st_data  = sd;
        sb.ld_valid = ldv;
        sb.ld_addr  = la;
        @(negedge clk);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic pulseReset();
        @(posedge clk);
        #1;
        rst         = 1'b1;
        sb.st_valid = 1'b0;
        sb.ld_valid = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("memWeInReset", 32'(sb.mem_we), 32'd0);
    endtask

    // Scoreboard monitor: every memory write must match the next expected
    // write, every serviced load the next expected load result.
    initial begin
        wrExp_t w;
        ldExp_t l;
        forever begin
            @(negedge clk);
            if (sb.mem_we === 1'b1) begin
                if (wrQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL unexpectedWrite: got addr 0x%08h data 0x%08h, expected no write",
                             sb.mem_addr, sb.mem_wd);
                end else begin
                    w = wrQ.pop_front();
                    checkOutput("memAddr", sb.mem_addr, w.addr);
                    checkOutput("memWd", sb.mem_wd, w.data);
                end
            end
            if (rst === 1'b0 && sb.ld_valid === 1'b1 && sb.ld_stall === 1'b0) begin
                if (ldQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL unexpectedLoad: got load of 0x%08h serviced, expected none",
                             sb.ld_addr);
                end else begin
                    l = ldQ.pop_front();
                    checkOutput("ldData", sb.ld_data, l.data);
                    checkOutput("ldFwd", 32'(sb.ld_fwd), 32'(l.fwd));
                    checkOutput("ldMemAddr", sb.mem_addr, l.addr);
                    checkOutput("ldMemWe", 32'(sb.mem_we), 32'd0);
                end
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no end of stimulus, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus with hand-computed expectations.
    initial begin
        int chk [14];

        for (int i = 0; i < 256; i++) begin
            mem[i]    = initWord(i);
            expMem[i] = initWord(i);
        end

        // Reset with a store presented: it must not be taken.
        rst         = 1'b1;
        sb.st_valid = 1'b1;
        sb.st_addr  = 32'h40;
        sb.st_data  = 32'hDEAD_BEEF;
        sb.ld_valid = 1'b0;
        sb.ld_addr  = 32'h0;
        @(posedge clk);
        idleCycle();
        checkOutput("rstStReady", 32'(sb.st_ready), 32'd1);
        checkOutput("rstEmpty", 32'(sb.sb_empty), 32'd1);
        checkOutput("rstCount", 32'(sb.sb_count), 32'd0);
        checkOutput("rstMemWe", 32'(sb.mem_we), 32'd0);
        checkOutput("rstLdStall", 32'(sb.ld_stall), 32'd0);
        checkOutput("rstLdFwd", 32'(sb.ld_fwd), 32'd0);

        // Single store drains one cycle after the push.
        expectWrite(32'h10, 32'hAAAA_5555);
        applyStimulus(1'b1, 32'h12, 32'hAAAA_5555, 1'b0, 32'h0);
        checkOutput("swStReady", 32'(sb.st_ready), 32'd1);
        checkOutput("swNoEarlyWe", 32'(sb.mem_we), 32'd0);
        idleCycle();
        checkOutput("swDrainWe", 32'(sb.mem_we), 32'd1);
        checkOutput("swCountBeforePop", 32'(sb.sb_count), 32'd1);
        idleCycle();
        checkOutput("swEmptyAfter", 32'(sb.sb_empty), 32'd1);
        checkOutput("swWeIdle", 32'(sb.mem_we), 32'd0);

        // Two stores to one word with a load every cycle: youngest wins,
        // nothing drains while loads occupy the port.
        expectWrite(32'h20, 32'd1);
        expectLoad(32'h20, initWord(8), 1'b0);
        applyStimulus(1'b1, 32'h20, 32'd1, 1'b1, 32'h20);
        checkOutput("fwdNoStall", 32'(sb.ld_stall), 32'd0);
        expectWrite(32'h20, 32'd2);
        expectLoad(32'h20, 32'd1, 1'b1);
        applyStimulus(1'b1, 32'h20, 32'd2, 1'b1, 32'h21);
        expectLoad(32'h20, 32'd2, 1'b1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h20);
        checkOutput("fwdCount2", 32'(sb.sb_count), 32'd2);
        expectLoad(32'h20, 32'd2, 1'b1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h23);
        checkOutput("fwdNoDrain", 32'(sb.mem_we), 32'd0);
        idleCycle();
        checkOutput("fwdDrain1", 32'(sb.mem_we), 32'd1);
        idleCycle();
        expectLoad(32'h20, 32'd2, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h20);
        checkOutput("fwdEmptyAfter", 32'(sb.sb_empty), 32'd1);

        // Fill the buffer under continuous loads, then full: store refused,
        // load stalls, one drain frees a slot and the load goes through.
        for (int i = 0; i < 4; i++) begin
            expectWrite(32'h40 + 32'(4 * i), 32'h100 + 32'(i));
            expectLoad(32'h80, initWord(32), 1'b0);
            applyStimulus(1'b1, 32'h40 + 32'(4 * i), 32'h100 + 32'(i), 1'b1, 32'h80);
            checkOutput("fillStReady", 32'(sb.st_ready), 32'd1);
        end
        applyStimulus(1'b1, 32'h50, 32'h104, 1'b1, 32'h80);
        checkOutput("fullStReady", 32'(sb.st_ready), 32'd0);
        checkOutput("fullLdStall", 32'(sb.ld_stall), 32'd1);
        checkOutput("fullCount", 32'(sb.sb_count), 32'd4);
        checkOutput("fullDrainWe", 32'(sb.mem_we), 32'd1);
        expectLoad(32'h80, initWord(32), 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h80);
        checkOutput("unstallLdStall", 32'(sb.ld_stall), 32'd0);
        checkOutput("unstallCount", 32'(sb.sb_count), 32'd3);
        expectLoad(32'h4C, 32'h103, 1'b1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h4C);
        repeat (3) idleCycle();
        idleCycle();
        checkOutput("fillEmptyAfter", 32'(sb.sb_empty), 32'd1);

        // Store and load to the same word in one cycle: memory value first,
        // buffered value the cycle after.
        expectWrite(32'h30, 32'h1234_5678);
        expectLoad(32'h30, initWord(12), 1'b0);
        applyStimulus(1'b1, 32'h30, 32'h1234_5678, 1'b1, 32'h30);
        expectLoad(32'h30, 32'h1234_5678, 1'b1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h30);
        idleCycle();
        idleCycle();
        checkOutput("sameCycEmpty", 32'(sb.sb_empty), 32'd1);

        // Three stores buffered then reset: none of them may reach memory.
        for (int i = 0; i < 3; i++) begin
            expectLoad(32'h84, initWord(33), 1'b0);
            applyStimulus(1'b1, 32'h60 + 32'(4 * i), 32'h600 + 32'(i), 1'b1, 32'h84);
            checkOutput("preRstMemWe", 32'(sb.mem_we), 32'd0);
        end
        checkOutput("preRstCount", 32'(sb.sb_count), 32'd2);
        pulseReset();
        idleCycle();
        checkOutput("postRstCount", 32'(sb.sb_count), 32'd0);
        checkOutput("postRstEmpty", 32'(sb.sb_empty), 32'd1);
        checkOutput("postRstMemWe", 32'(sb.mem_we), 32'd0);
        repeat (3) idleCycle();

        // Ten stores over three words with drains in between; pointers wrap
        // several times and memory must end with the last store to each word.
        for (int i = 0; i < 10; i++) begin
            expectWrite(32'h100 + 32'(4 * (i % 3)), 32'h7000 + 32'(i));
            if (i % 2 == 0) begin
                expectLoad(32'h200, initWord(128), 1'b0);
            end
            applyStimulus(1'b1, 32'h100 + 32'(4 * (i % 3)), 32'h7000 + 32'(i),
                          (i % 2 == 0), 32'h200);
            checkOutput("wrapStReady", 32'(sb.st_ready), 32'd1);
            if (i % 2 == 1) begin
                idleCycle();
            end
        end
        idleCycle();
        idleCycle();
        checkOutput("wrapEmpty", 32'(sb.sb_empty), 32'd1);

        // Final memory image and queue drain.
        chk = '{4, 8, 12, 16, 17, 18, 19, 24, 25, 26, 64, 65, 66, 32};
        foreach (chk[j]) begin
            checkOutput($sformatf("memImage[0x%03h]", chk[j] * 4), mem[chk[j]], expMem[chk[j]]);
        end
        checkOutput("wrQueueLeft", 32'(wrQ.size()), 32'd0);
        checkOutput("ldQueueLeft", 32'(ldQ.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
